timer_arbiter: RTL



---
 rtl/timer_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/timer_arbiter.sv
// rtl/timer_arbiter.sv - one countdown timer shared round-robin between NUM_REQ requesters
module timer_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_DURATION = 2000,
    localparam int DW          = $clog2(MAX_DURATION + 1),
    localparam int IW          = $clog2(NUM_REQ)
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ*DW-1:0] duration_i,
    output logic [NUM_REQ-1:0]    grant_o,
    output logic [NUM_REQ-1:0]    done_o,
    output logic                  busy_o,
    output logic [DW-1:0]         count_o,
    output logic [IW-1:0]         active_id_o
);

    localparam int CW = IW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0]      MAX_D    = DW'(MAX_DURATION);

    logic [1:0]         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] done_q;
    logic [DW-1:0]      count_q;
    logic [IW-1:0]      active_id_q;
    logic [IW-1:0]      last_winner_q;

    logic [IW-1:0]      winner;
    logic               found;
    logic [CW-1:0]      cand;
    logic [DW-1:0]      dur_raw;
    logic [DW-1:0]      dur_clamped;

    // Search starts just after the last winner so a held request cannot starve others.
    always_comb begin
        winner = last_winner_q;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_winner_q} + CW'(i);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!found && req_i[cand[IW-1:0]]) begin
                winner = cand[IW-1:0];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        dur_raw     = duration_i[winner*DW +: DW];
        dur_clamped = (dur_raw > MAX_D) ? MAX_D : dur_raw;
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            done_q        <= '0;
            count_q       <= '0;
            active_id_q   <= '0;
            last_winner_q <= IW'(NUM_REQ - 1);
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        state_q       <= S_RUN;
                        grant_q       <= ONE_HOT0 << winner;
                        active_id_q   <= winner;
                        last_winner_q <= winner;
                        count_q       <= dur_clamped;
                    end
                end
                S_RUN: begin
                    if (!req_i[active_id_q]) begin
                        state_q <= S_IDLE;
                        grant_q <= '0;
                        count_q <= '0;
                    end else if (count_q == '0) begin
                        state_q <= S_DONE;
                        grant_q <= '0;
                        done_q  <= ONE_HOT0 << active_id_q;
                    end else begin
                        count_q <= count_q - DW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= '0;
                end
                default: begin
                    state_q <= S_IDLE;
                    grant_q <= '0;
                    done_q  <= '0;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != S_IDLE);
    assign count_o     = count_q;
    assign active_id_o = active_id_q;

endmodule
